// File: rtl/dft_pkg.sv
// Shared types and default sizing for the DFT multiply-accumulate core.
package dft_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAddrW = 12;
  localparam int unsigned DefAccW  = 40;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StDrain,
    StEmit,
    StFin
  } dft_state_e;

endpackage

// File: rtl/cmplx_mul_round.sv
// Registered complex multiply of sample by twiddle, rounded half-up back to
// sample scale. real_in zeroes the sample imaginary part; inverse conjugates w.
module cmplx_mul_round #(
  parameter int unsigned DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  n_Reset,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     a_re,
  input  logic [DATA_W-1:0]     a_im,
  input  logic [DATA_W-1:0]     w_re,
  input  logic [DATA_W-1:0]     w_im,
  input  logic                  real_in,
  input  logic                  inverse,
  output logic                  out_valid,
  output logic [2*DATA_W+1:0]   p_re,
  output logic [2*DATA_W+1:0]   p_im
);

  // One guard bit above the 2*DATA_W+1 product so negating -2^(DATA_W-1) is exact.
  localparam int unsigned PW = 2 * DATA_W + 2;

  logic signed [PW-1:0] ar, ai, wr, wi, prod_re, prod_im, bias;
  logic        [PW-1:0] rnd_re_d, rnd_im_d, rnd_re_q, rnd_im_q;
  logic                 valid_q;

  always_comb begin
    ar       = PW'($signed(a_re));
    ai       = real_in ? '0 : PW'($signed(a_im));
    wr       = PW'($signed(w_re));
    wi       = inverse ? -PW'($signed(w_im)) : PW'($signed(w_im));
    bias     = '0;
    bias[DATA_W-2] = 1'b1;
    prod_re  = ar * wr - ai * wi;
    prod_im  = ar * wi + ai * wr;
    rnd_re_d = PW'((prod_re + bias) >>> (DATA_W - 1));
    rnd_im_d = PW'((prod_im + bias) >>> (DATA_W - 1));
  end

  always_ff @(posedge clk or negedge n_Reset) begin
    if (!n_Reset) begin
      valid_q  <= 1'b0;
      rnd_re_q <= '0;
      rnd_im_q <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        rnd_re_q <= rnd_re_d;
        rnd_im_q <= rnd_im_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign p_re      = rnd_re_q;
  assign p_im      = rnd_im_q;

endmodule

// File: rtl/dft_mac_core.sv
// Direct-form DFT engine: for each bin k, streams n = 0..N-1 through one complex
// multiplier, accumulates, then hands the bin result out on a valid/ready port.
module dft_mac_core
  import dft_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned ACC_W  = DefAccW
) (
  input  logic              clk,
  input  logic              n_Reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] samp_num,
  input  logic              real_in,
  input  logic              inverse,
  output logic [ADDR_W-1:0] smp_addr,
  input  logic [DATA_W-1:0] smp_re,
  input  logic [DATA_W-1:0] smp_im,
  output logic [ADDR_W-1:0] tw_k,
  output logic [ADDR_W-1:0] tw_n,
  input  logic [DATA_W-1:0] tw_re,
  input  logic [DATA_W-1:0] tw_im,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ADDR_W-1:0] res_k,
  output logic [ACC_W-1:0]  res_re,
  output logic [ACC_W-1:0]  res_im,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PW = 2 * DATA_W + 2;

  dft_state_e        state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d, k_q, k_d, num_q, num_d;
  logic              real_q, real_d, inv_q, inv_d;
  logic              drain_q, drain_d;
  logic [ACC_W-1:0]  acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic              iss_q;
  logic              res_valid_q, busy_q, done_q;
  logic              prod_valid;
  logic [PW-1:0]     prod_re, prod_im;

  cmplx_mul_round #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk       (clk),
    .n_Reset   (n_Reset),
    .in_valid  (iss_q),
    .a_re      (smp_re),
    .a_im      (smp_im),
    .w_re      (tw_re),
    .w_im      (tw_im),
    .real_in   (real_q),
    .inverse   (inv_q),
    .out_valid (prod_valid),
    .p_re      (prod_re),
    .p_im      (prod_im)
  );

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    k_d      = k_q;
    num_d    = num_q;
    real_d   = real_q;
    inv_d    = inv_q;
    drain_d  = drain_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    if (prod_valid) begin
      acc_re_d = acc_re_q + ACC_W'($signed(prod_re));
      acc_im_d = acc_im_q + ACC_W'($signed(prod_im));
    end
    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_d    = samp_num;
          real_d   = real_in;
          inv_d    = inverse;
          k_d      = '0;
          n_d      = '0;
          acc_re_d = '0;
          acc_im_d = '0;
          state_d  = (samp_num == '0) ? StFin : StAccum;
        end
      end
      StAccum: begin
        if (n_q == num_q - ADDR_W'(1)) begin
          drain_d = 1'b0;
          state_d = StDrain;
        end else begin
          n_d = n_q + ADDR_W'(1);
        end
      end
      // Two cycles: one for the sample/twiddle read, one for the product register.
      StDrain: begin
        if (drain_q) state_d = StEmit;
        else         drain_d = 1'b1;
      end
      StEmit: begin
        if (res_ready) begin
          if (k_q == num_q - ADDR_W'(1)) begin
            state_d = StFin;
          end else begin
            k_d      = k_q + ADDR_W'(1);
            n_d      = '0;
            acc_re_d = '0;
            acc_im_d = '0;
            state_d  = StAccum;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_Reset) begin
    if (!n_Reset) begin
      state_q     <= StIdle;
      n_q         <= '0;
      k_q         <= '0;
      num_q       <= '0;
      real_q      <= 1'b0;
      inv_q       <= 1'b0;
      drain_q     <= 1'b0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      iss_q       <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      k_q         <= k_d;
      num_q       <= num_d;
      real_q      <= real_d;
      inv_q       <= inv_d;
      drain_q     <= drain_d;
      acc_re_q    <= acc_re_d;
      acc_im_q    <= acc_im_d;
      iss_q       <= (state_q == StAccum);
      res_valid_q <= (state_d == StEmit);
      busy_q      <= (state_d != StIdle);
      done_q      <= (state_d == StFin);
    end
  end

  assign smp_addr  = n_q;
  assign tw_n      = n_q;
  assign tw_k      = k_q;
  assign res_k     = k_q;
  assign res_re    = acc_re_q;
  assign res_im    = acc_im_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dft_mac_core.sv
// Scoreboard bench for dft_mac_core: a reference DFT pushes expected bins,
// a negedge monitor pops and compares each accepted result.
module tb_dft_mac_core;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int CW = 40;

  logic          clk = 1'b0;
  logic          n_Reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] samp_num = '0;
  logic          real_in = 1'b0;
  logic          inverse = 1'b0;
  logic [AW-1:0] smp_addr, tw_k, tw_n, res_k;
  logic [DW-1:0] smp_re, smp_im, tw_re, tw_im;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [CW-1:0] res_re, res_im;
  logic          busy, done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int cur_n = 0;

  logic [DW-1:0] mem_re[64], mem_im[64], twr[64], twi[64];
  logic [CW-1:0] got_re[64], got_im[64];

  typedef struct {
    logic [AW-1:0] k;
    logic [CW-1:0] re;
    logic [CW-1:0] im;
  } exp_t;
  exp_t sbq[$];

  dft_mac_core dut (
    .clk       (clk),
    .n_Reset   (n_Reset),
    .start     (start),
    .samp_num  (samp_num),
    .real_in   (real_in),
    .inverse   (inverse),
    .smp_addr  (smp_addr),
    .smp_re    (smp_re),
    .smp_im    (smp_im),
    .tw_k      (tw_k),
    .tw_n      (tw_n),
    .tw_re     (tw_re),
    .tw_im     (tw_im),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_k     (res_k),
    .res_re    (res_re),
    .res_im    (res_im),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic int tw_idx(logic [AW-1:0] k, logic [AW-1:0] n);
    if (cur_n == 0) return 0;
    return ((int'(k) * int'(n)) % cur_n);
  endfunction

  // Synchronous-read sample RAM and twiddle ROM models.
  always @(posedge clk) begin
    smp_re <= mem_re[smp_addr[5:0]];
    smp_im <= mem_im[smp_addr[5:0]];
    tw_re  <= twr[tw_idx(tw_k, tw_n)];
    tw_im  <= twi[tw_idx(tw_k, tw_n)];
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic          hold_v = 1'b0;
  logic [AW-1:0] hold_k;
  logic [CW-1:0] hold_re, hold_im;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check("done_after_last_result", 64'(sbq.size()), 64'd0);
    end
    if (res_valid) begin
      if (hold_v) begin
        check("hold_k", 64'(res_k), 64'(hold_k));
        check("hold_re", 64'(res_re), 64'(hold_re));
        check("hold_im", 64'(res_im), 64'(hold_im));
      end
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got k=%0d expected none", res_k);
      end else if (res_ready) begin
        exp_t e;
        e = sbq.pop_front();
        check("res_k", 64'(res_k), 64'(e.k));
        check("res_re", 64'(res_re), 64'(e.re));
        check("res_im", 64'(res_im), 64'(e.im));
        got_re[res_k[5:0]] = res_re;
        got_im[res_k[5:0]] = res_im;
      end
      hold_v  = !res_ready;
      hold_k  = res_k;
      hold_re = res_re;
      hold_im = res_im;
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic tick(int c = 1);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int rnd(real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

  task automatic set_tw(int nn);
    cur_n = nn;
    for (int i = 0; i < nn; i++) begin
      real th;
      th = 6.283185307179586 * i / nn;
      twr[i] = DW'(rnd(32767.0 * $cos(th)));
      twi[i] = DW'(rnd(-32767.0 * $sin(th)));
    end
  endtask

  // X[k] = sum_n round(x[n] * W^(kn)), each term rounded half-up to Q1.15 scale.
  task automatic push_expected(int nn, bit rl, bit inv);
    for (int k = 0; k < nn; k++) begin
      longint sr, si, ar, ai, wr, wi, pr, pi;
      exp_t e;
      sr = 0;
      si = 0;
      for (int n = 0; n < nn; n++) begin
        ar = longint'($signed(mem_re[n]));
        ai = rl ? 0 : longint'($signed(mem_im[n]));
        wr = longint'($signed(twr[(k * n) % nn]));
        wi = longint'($signed(twi[(k * n) % nn]));
        if (inv) wi = -wi;
        pr = ar * wr - ai * wi;
        pi = ar * wi + ai * wr;
        sr += (pr + (64'sd1 <<< (DW - 2))) >>> (DW - 1);
        si += (pi + (64'sd1 <<< (DW - 2))) >>> (DW - 1);
      end
      e.k  = AW'(k);
      e.re = sr[CW-1:0];
      e.im = si[CW-1:0];
      sbq.push_back(e);
    end
  endtask

  task automatic start_tf(int nn, bit rl, bit inv);
    set_tw(nn);
    push_expected(nn, rl, inv);
    start    = 1'b1;
    samp_num = AW'(nn);
    real_in  = rl;
    inverse  = inv;
    tick();
    start    = 1'b0;
    samp_num = AW'($urandom);
    real_in  = 1'($urandom);
    inverse  = 1'($urandom);
  endtask

  task automatic drain(int cnt, int stall);
    for (int r = 0; r < cnt; r++) begin
      int t;
      t = 0;
      while (!res_valid && t < 200) begin
        tick();
        t++;
      end
      if (!res_valid) begin
        checks++;
        errors++;
        $display("FAIL result_timeout: got no res_valid expected result %0d", r);
        return;
      end
      tick(stall);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end
  endtask

  task automatic run_tf(int nn, bit rl, bit inv, int stall);
    start_tf(nn, rl, inv);
    drain(nn, stall);
    exp_done++;
    tick(3);
    check("done_count", 64'(done_cnt), 64'(exp_done));
    check("busy_after_fin", 64'(busy), 64'd0);
  endtask

  task automatic fill(int mode);
    for (int i = 0; i < 64; i++) begin
      case (mode)
        0: begin mem_re[i] = 16'h4000; mem_im[i] = '0; end
        1: begin mem_re[i] = (i == 0) ? 16'h4000 : '0; mem_im[i] = '0; end
        2: begin mem_re[i] = '0; mem_im[i] = 16'h4000; end
        default: begin mem_re[i] = DW'($urandom); mem_im[i] = DW'($urandom); end
      endcase
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] im1_f, im3_f;
    longint v;
    fill(3);
    set_tw(1);
    #1 n_Reset = 1'b0;
    #2;
    check("rst_res_valid", 64'(res_valid), 0);
    check("rst_done", 64'(done), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_smp_addr", 64'(smp_addr), 0);
    check("rst_tw_k", 64'(tw_k), 0);
    check("rst_tw_n", 64'(tw_n), 0);
    check("rst_res_k", 64'(res_k), 0);
    check("rst_res_re", 64'(res_re), 0);
    check("rst_res_im", 64'(res_im), 0);
    tick(2);
    n_Reset = 1'b1;
    tick(2);

    // Constant real input: all energy in bin 0.
    fill(0);
    run_tf(4, 1'b0, 1'b0, 0);
    check("dc_k0_re", 64'(got_re[0]), 64'h10000);
    check("dc_k0_im", 64'(got_im[0]), 0);
    for (int k = 1; k < 4; k++) begin
      v = longint'($signed(got_re[k]));
      check("dc_leak_re", 64'(v <= 4 && v >= -4), 1);
      v = longint'($signed(got_im[k]));
      check("dc_leak_im", 64'(v <= 4 && v >= -4), 1);
    end

    // Impulse: flat spectrum, then again with back-pressure.
    fill(1);
    run_tf(4, 1'b0, 1'b0, 0);
    for (int k = 0; k < 4; k++) begin
      check("imp_re", 64'(got_re[k]), 64'h4000);
      check("imp_im", 64'(got_im[k]), 0);
    end
    run_tf(4, 1'b0, 1'b0, 5);

    // Zero-length transform: done the cycle after start, no results.
    start    = 1'b1;
    samp_num = '0;
    tick();
    start = 1'b0;
    check("zero_len_done", 64'(done), 1);
    exp_done++;
    tick(3);
    check("zero_len_done_count", 64'(done_cnt), 64'(exp_done));

    // Start while busy is ignored.
    fill(3);
    start_tf(4, 1'b0, 1'b0);
    tick(3);
    start    = 1'b1;
    samp_num = AW'(7);
    tick();
    start = 1'b0;
    drain(4, 1);
    exp_done++;
    tick(20);
    check("busy_start_done_count", 64'(done_cnt), 64'(exp_done));
    check("busy_start_idle", 64'(busy), 0);

    // Forward vs inverse on a pure imaginary input.
    fill(2);
    run_tf(4, 1'b0, 1'b0, 0);
    im1_f = got_im[1];
    im3_f = got_im[3];
    run_tf(4, 1'b0, 1'b1, 0);
    check("inv_swap_k1", 64'(got_im[1]), 64'(im3_f));
    check("inv_swap_k3", 64'(got_im[3]), 64'(im1_f));

    // Single-point transform.
    fill(3);
    run_tf(1, 1'b0, 1'b0, 0);

    // Reset during ACCUM of k=2.
    start_tf(4, 1'b0, 1'b0);
    drain(2, 0);
    tick(1);
    n_Reset = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 0);
    check("mid_rst_res_valid", 64'(res_valid), 0);
    check("mid_rst_smp_addr", 64'(smp_addr), 0);
    check("mid_rst_tw_k", 64'(tw_k), 0);
    check("mid_rst_res_re", 64'(res_re), 0);
    check("mid_rst_res_im", 64'(res_im), 0);
    sbq.delete();
    tick(2);
    n_Reset = 1'b1;
    tick(3);
    check("mid_rst_no_done", 64'(done_cnt), 64'(exp_done));
    run_tf(4, 1'b0, 1'b0, 0);

    // Randomized transforms.
    for (int it = 0; it < 6; it++) begin
      fill(3);
      run_tf($urandom_range(1, 12), 1'($urandom), 1'($urandom), $urandom_range(0, 2));
    end

    check("scoreboard_empty", 64'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dft_mac_core.md
DFT_MAC_CORE -- requirements
Module: dft_mac_core

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning sample/twiddle width, signed Q1.(DATA_W-1).
REQ-002 SHALL have parameter ADDR_W, default 12, meaning sample-index width.
REQ-003 SHALL have parameter ACC_W, default 40, meaning signed accumulator and result width (ACC_W >= DATA_W+ADDR_W+1).
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  clock; n_Reset  in  1  async active-low reset.
REQ-005 start  in  1  one-cycle request to begin a transform.
REQ-006 samp_num  in  ADDR_W  transform length N, sampled on accepted start.
REQ-007 real_in  in  1  1: ignore smp_im, treat input as real; sampled on start.
REQ-008 inverse  in  1  1: conjugate twiddle (negate tw_im); sampled on start.
REQ-009 smp_addr  out  ADDR_W  sample read index n.
REQ-010 smp_re, smp_im  in  DATA_W each  sample data, valid exactly 1 cycle after smp_addr.
REQ-011 tw_k, tw_n  out  ADDR_W each  twiddle ROM indices.
REQ-012 tw_re, tw_im  in  DATA_W each  twiddle data, valid exactly 1 cycle after tw_k/tw_n.
REQ-013 res_valid  out  1; res_ready  in  1; res_k  out  ADDR_W; res_re, res_im  out  ACC_W each: result stream.
REQ-014 busy  out  1  high outside IDLE; done  out  1  one-cycle pulse at end of transform.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM, DRAIN, EMIT, FIN.
REQ-016 IDLE + start: latch samp_num/real_in/inverse, clear k, n, accumulators; go ACCUM; if samp_num==0 go FIN instead.
REQ-017 start SHALL be ignored when not in IDLE.
REQ-018 ACCUM: each cycle drive smp_addr=tw_n=n, tw_k=k, n increments; after issuing n=N-1 go DRAIN.
REQ-019 Pipeline: stage1 register read data; stage2 register complex product; accumulate on stage2 output; total issue-to-accumulate latency 2 cycles.
REQ-020 Product: p_re=a_re*w_re - a_im*w_im, p_im=a_re*w_im + a_im*w_re, with a_im=0 when real_in, w_im negated when inverse; full 2*DATA_W+1 precision.
REQ-021 Each product SHALL be rounded half-up to (p + 2^(DATA_W-2)) >>> (DATA_W-1), sign-extended to ACC_W, then added; accumulator wraps modulo 2^ACC_W (no saturation).
REQ-022 DRAIN SHALL last exactly 2 cycles so the last product is accumulated, then go EMIT.
REQ-023 EMIT: res_valid=1, res_k=k, res_re/res_im=accumulators, all stable until res_ready.
REQ-024 On res_valid&&res_ready: if k==N-1 go FIN, else k++, n=0, clear accumulators, go ACCUM next cycle.
REQ-025 FIN: done=1 for one cycle, go IDLE; results 0..N-1 emitted in ascending k, exactly N per transform.
REQ-026 N==1: one ACCUM cycle, DRAIN, one result (k=0), FIN.
REQ-027 samp_num, real_in, inverse changes after start SHALL not affect the running transform.

Reset
REQ-028 n_Reset low SHALL asynchronously force IDLE, n=k=0, accumulators=0, pipeline registers=0.
REQ-029 Reset values: res_valid=0, done=0, busy=0, smp_addr=tw_n=tw_k=res_k=0, res_re=res_im=0.
REQ-030 Reset mid-transform SHALL abandon it with no done pulse; next start after release runs normally.

Structure
REQ-031 Shared package dft_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-032 One sub-module cmplx_mul_round (registered complex multiply + rounding, real_in/inverse controls) SHALL be instantiated once.

Verification
REQ-033 N=4, all smp_re=0x4000, smp_im=0, ideal Q1.15 twiddles (W0=0x7FFF): res k=0 re=0x10000 im=0; k=1..3 |re|,|im|<=4.
REQ-034 N=4, impulse smp_re[0]=0x4000 others 0: all four results re=0x4000, im=0; done pulses once after 4th handshake.
REQ-035 Same as 034 with res_ready low 5 cycles per result: outputs held stable, no result lost or duplicated.
REQ-036 samp_num=0 start: done in 2 cycles, res_valid never high; start pulsed while busy: ignored, exactly N results.
REQ-037 inverse=1 vs 0 with smp=(0,0x4000), N=4: im results of k=1 and k=3 swap.
REQ-038 n_Reset asserted during ACCUM of k=2: outputs zero immediately, no done; rerun yields correct full result set.
